// File: rtl/bus_resolver.sv
// Shared-bus hub: resolves all register drivers into one wired-AND bus value,
// registers it with the last owner, and tracks contention into a sticky fault.
module bus_resolver #(
   parameter int unsigned WIDTH                = 8,
   parameter int unsigned NUM_DRIVERS          = 4,
   parameter logic [WIDTH-1:0] PULL_VALUE      = 8'hff,
   parameter int unsigned CNT_WIDTH            = 8,
   localparam int unsigned IDX_W = (NUM_DRIVERS > 1) ? $clog2(NUM_DRIVERS) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_DRIVERS*WIDTH-1:0]  drv_data,
   input  logic [NUM_DRIVERS-1:0]        drv_en,
   input  logic                          clear_fault,
   output logic [WIDTH-1:0]              bus_value,
   output logic                          bus_driven,
   output logic                          contention,
   output logic [WIDTH-1:0]              bus_q,
   output logic [IDX_W-1:0]              owner_q,
   output logic [1:0]                    state,
   output logic                          fault,
   output logic [CNT_WIDTH-1:0]          contention_count
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DRIVEN     = 2'd1,
      CONTENTION = 2'd2,
      FAULT      = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      and_acc;
   logic                  any_en;
   logic                  multi_en;
   logic [IDX_W-1:0]      low_idx;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [IDX_W-1:0]      owner_r;
   logic [WIDTH-1:0]      bus_r;

   // One scan gives the wired-AND, the enable population class and the lowest owner.
   always_comb begin
      and_acc  = '1;
      any_en   = 1'b0;
      multi_en = 1'b0;
      low_idx  = '0;
      for (int unsigned i = 0; i < NUM_DRIVERS; i++) begin
         if (drv_en[i]) begin
            and_acc = and_acc & drv_data[i*WIDTH +: WIDTH];
            if (any_en) begin
               multi_en = 1'b1;
            end else begin
               low_idx = IDX_W'(i);
            end
            any_en = 1'b1;
         end
      end
   end

   assign bus_value  = any_en ? and_acc : PULL_VALUE;
   assign bus_driven = any_en;
   assign contention = multi_en;

   always_comb begin
      state_d = state_q;
      if (clear_fault) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DRIVEN: begin
               if (multi_en)    state_d = CONTENTION;
               else if (any_en) state_d = DRIVEN;
               else             state_d = IDLE;
            end
            CONTENTION: begin
               if (multi_en)    state_d = FAULT;
               else if (any_en) state_d = DRIVEN;
               else             state_d = IDLE;
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bus_r   <= PULL_VALUE;
         owner_r <= '0;
      end else begin
         state_q <= state_d;
         bus_r   <= bus_value;
         if (any_en) owner_r <= low_idx;
         if (clear_fault) begin
            cnt_q <= '0;
         end else if (multi_en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   assign bus_q            = bus_r;
   assign owner_q          = owner_r;
   assign state            = state_q;
   assign fault            = (state_q == FAULT);
   assign contention_count = cnt_q;

endmodule

// File: tb/tb_bus_resolver.sv
// Directed bench for bus_resolver: an abstract bus model checked every cycle,
// plus literal expectations along the documented scenarios.
module tb_bus_resolver;

   localparam int unsigned W = 8;
   localparam int unsigned N = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*W-1:0]  drv_data;
   logic [N-1:0]    drv_en;
   logic            clear_fault;

   logic [W-1:0]    bus_value, bus_q;
   logic            bus_driven, contention, fault;
   logic [1:0]      owner_q, state;
   logic [7:0]      contention_count;

   logic [W-1:0]    bus_value2, bus_q2;
   logic            bus_driven2, contention2, fault2;
   logic [1:0]      owner_q2, state2;
   logic [1:0]      contention_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_resolver #(.WIDTH(8), .NUM_DRIVERS(4), .PULL_VALUE(8'hff), .CNT_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .drv_data(drv_data), .drv_en(drv_en),
      .clear_fault(clear_fault), .bus_value(bus_value), .bus_driven(bus_driven),
      .contention(contention), .bus_q(bus_q), .owner_q(owner_q), .state(state),
      .fault(fault), .contention_count(contention_count)
   );

   bus_resolver #(.WIDTH(8), .NUM_DRIVERS(4), .PULL_VALUE(8'hff), .CNT_WIDTH(2)) dut_c2 (
      .clk(clk), .reset(reset), .drv_data(drv_data), .drv_en(drv_en),
      .clear_fault(clear_fault), .bus_value(bus_value2), .bus_driven(bus_driven2),
      .contention(contention2), .bus_q(bus_q2), .owner_q(owner_q2), .state(state2),
      .fault(fault2), .contention_count(contention_count2)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Abstract model: bus value from the enabled slot set, FSM as a run length of
   // contention samples plus a sticky flag.
   function automatic int model_bus(input logic [N-1:0] en, input logic [N*W-1:0] d);
      int v;
      if (en == 0) return 'hff;
      v = 'hff;
      for (int i = 0; i < N; i++)
         if (en[i]) v = v & int'(d[i*W +: W]);
      return v;
   endfunction

   function automatic int lowest(input logic [N-1:0] en);
      for (int i = 0; i < N; i++)
         if (en[i]) return i;
      return 0;
   endfunction

   bit model_valid = 0;
   int m_bus_q, m_owner, m_state, m_cnt8, m_cnt2, m_run;
   bit m_fault;

   always @(posedge clk) begin
      int pop;
      pop = $countones(drv_en);
      if (reset) begin
         m_bus_q = 'hff; m_owner = 0; m_state = 0; m_cnt8 = 0; m_cnt2 = 0;
         m_run = 0; m_fault = 0; model_valid = 1;
      end else if (model_valid) begin
         m_bus_q = model_bus(drv_en, drv_data);
         if (pop > 0) m_owner = lowest(drv_en);
         if (clear_fault) begin
            m_fault = 0; m_run = 0; m_state = 0; m_cnt8 = 0; m_cnt2 = 0;
         end else begin
            m_run = (pop >= 2) ? m_run + 1 : 0;
            if (m_run >= 2) m_fault = 1;
            if (pop >= 2) begin
               m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
               m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
            m_state = m_fault ? 3 : (pop >= 2) ? 2 : (pop > 0) ? 1 : 0;
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (model_valid) begin
         chk("m_bus_value", bus_value, model_bus(drv_en, drv_data));
         chk("m_bus_driven", bus_driven, int'($countones(drv_en) > 0));
         chk("m_contention", contention, int'($countones(drv_en) > 1));
         chk("m_bus_q", bus_q, m_bus_q);
         chk("m_owner_q", owner_q, m_owner);
         chk("m_state", state, m_state);
         chk("m_fault", fault, int'(m_fault));
         chk("m_count", contention_count, m_cnt8);
         chk("m_count_c2", contention_count2, m_cnt2);
      end
   end

   task automatic ap(input logic [3:0] en, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [7:0] d2, input logic [7:0] d3,
                     input logic clr, input logic rst);
      @(negedge clk);
      drv_en      = en;
      drv_data    = {d3, d2, d1, d0};
      clear_fault = clr;
      reset       = rst;
      #3;
   endtask

   initial begin
      reset = 1'b1; drv_en = '0; drv_data = '0; clear_fault = 1'b0;
      ap(4'b0000, 0, 0, 0, 0, 0, 1);
      ap(4'b0000, 0, 0, 0, 0, 0, 1);
      repeat (3) ap(4'b0000, 0, 0, 0, 0, 0, 0);
      chk("idle_bus_value", bus_value, 'hff);
      chk("idle_bus_driven", bus_driven, 0);
      chk("idle_bus_q", bus_q, 'hff);
      chk("idle_state", state, 0);
      chk("idle_owner", owner_q, 0);
      chk("idle_count", contention_count, 0);

      ap(4'b0100, 0, 0, 8'h3c, 0, 0, 0);
      chk("single_bus_value", bus_value, 'h3c);
      chk("single_driven", bus_driven, 1);
      ap(4'b0000, 0, 0, 0, 0, 0, 0);
      chk("single_bus_q", bus_q, 'h3c);
      chk("single_owner", owner_q, 2);
      chk("single_state", state, 1);
      chk("release_bus_value", bus_value, 'hff);
      ap(4'b0000, 0, 0, 0, 0, 0, 0);
      chk("release_state", state, 0);
      chk("release_owner_hold", owner_q, 2);

      ap(4'b0011, 8'hf0, 8'h3c, 0, 0, 0, 0);
      chk("cont_bus_value", bus_value, 'h30);
      chk("cont_flag", contention, 1);
      ap(4'b0010, 0, 8'h3c, 0, 0, 0, 0);
      chk("cont_state", state, 2);
      chk("cont_owner", owner_q, 0);
      chk("cont_count", contention_count, 1);
      chk("cont_bus_q", bus_q, 'h30);
      ap(4'b0000, 0, 0, 0, 0, 0, 0);
      chk("recover_state", state, 1);
      chk("recover_fault", fault, 0);
      chk("recover_owner", owner_q, 1);

      ap(4'b0000, 0, 0, 0, 0, 1, 0);
      ap(4'b0011, 8'hf0, 8'h3c, 0, 0, 0, 0);
      ap(4'b0011, 8'h0f, 8'hff, 0, 0, 0, 0);
      ap(4'b0001, 8'h11, 0, 0, 0, 0, 0);
      chk("fault_state", state, 3);
      chk("fault_flag", fault, 1);
      chk("fault_count", contention_count, 2);
      chk("fault_bus_q", bus_q, 'h0f);
      ap(4'b0001, 8'h22, 0, 0, 0, 0, 0);
      chk("sticky_bus_q1", bus_q, 'h11);
      ap(4'b0001, 8'h33, 0, 0, 0, 0, 0);
      chk("sticky_bus_q2", bus_q, 'h22);
      ap(4'b0000, 0, 0, 0, 0, 0, 0);
      chk("sticky_bus_q3", bus_q, 'h33);
      chk("sticky_fault", fault, 1);

      ap(4'b1001, 8'haa, 0, 0, 8'h55, 1, 0);
      chk("clr_bus_value", bus_value, 'h00);
      ap(4'b0000, 0, 0, 0, 0, 0, 0);
      chk("clr_state", state, 0);
      chk("clr_count", contention_count, 0);
      chk("clr_fault", fault, 0);
      chk("clr_owner", owner_q, 0);
      chk("clr_bus_q", bus_q, 'h00);

      ap(4'b0011, 8'hff, 8'hff, 0, 0, 0, 0);
      ap(4'b0011, 8'hff, 8'hff, 0, 0, 0, 0);
      ap(4'b0000, 0, 0, 0, 0, 0, 0);
      chk("refault_state", state, 3);
      ap(4'b0011, 8'h12, 8'h34, 0, 0, 0, 1);
      ap(4'b0000, 0, 0, 0, 0, 0, 0);
      chk("rst_bus_q", bus_q, 'hff);
      chk("rst_owner", owner_q, 0);
      chk("rst_state", state, 0);
      chk("rst_fault", fault, 0);
      chk("rst_count", contention_count, 0);

      repeat (5) ap(4'b0110, 0, 8'hff, 8'hff, 0, 0, 0);
      ap(4'b0000, 0, 0, 0, 0, 0, 0);
      chk("sat_count_c2", contention_count2, 3);
      chk("sat_count_c8", contention_count, 5);
      chk("sat_state", state, 3);

      ap(4'b0000, 0, 0, 0, 0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
